xor_parity_rx: RTL
==================

Name: xor_parity_rx

Overview:
Serial frame receiver and parity checker. It is the receive end of the team's XOR parity generator path. It shifts in LSB-first data bits followed by one parity bit, and recomputes parity with a running XOR. It presents the deserialised word with a pass/fail flag on a valid/ready output port, and keeps a saturating error counter.

Parameters:
DATA_W, 8, data bits per frame (min 2)
ODD_PARITY, 0, 0 = even parity expected, 1 = odd parity expected
ERR_CNT_W, 8, width of saturating parity error counter

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous reset, active-high
sin_valid  input  1  sin_bit/sin_start qualify this cycle
sin_bit  input  1  serial bit (data LSB first, then parity)
sin_start  input  1  marks the first data bit of a frame (sampled only with sin_valid)
dout  output  DATA_W  received data word
dout_valid  output  1  dout/parity_err valid, held until accepted
dout_ready  input  1  downstream accepts when dout_valid & dout_ready
parity_err  output  1  parity mismatch for word on dout
err_count  output  ERR_CNT_W  saturating count of parity errors
overrun  output  1  one-cycle pulse: completed frame dropped
frame_abort  output  1  one-cycle pulse: frame restarted by mid-frame sin_start

Behaviour:
- Reset (async assert, sync release): state IDLE, shift reg 0, bit count 0, running XOR 0. dout=0, dout_valid=0, parity_err=0, err_count=0, overrun=0, frame_abort=0.
- Cycles without sin_valid: no state change.
- IDLE:
  - sin_valid & sin_start: load bit 0 = sin_bit, xor = sin_bit, count = 1, go to DATA.
  - sin_valid & !sin_start: bit ignored.
- DATA: each sin_valid bit is shifted into position count, xor ^= sin_bit, count++. When count reaches DATA_W, go to PARITY.
- PARITY: the next sin_valid bit is the parity bit.
  - err = xor ^ sin_bit ^ ODD_PARITY.
  - Go to IDLE; the frame is "complete" this cycle.
- Mid-frame restart: sin_valid & sin_start in DATA or PARITY aborts the current frame.
  - frame_abort pulses the next cycle.
  - The bit is treated as data bit 0 of a new frame (same as the IDLE start case).
  - Nothing is emitted for the aborted frame.
- Completion with output slot free (dout_valid=0, or dout_valid & dout_ready this same cycle):
  - Next cycle: dout = word, parity_err = err, dout_valid = 1.
  - Latency is 1 cycle from parity bit sample to dout_valid.
- Completion with output slot occupied (dout_valid & !dout_ready):
  - The new frame is dropped.
  - overrun pulses the next cycle.
  - dout and parity_err are unchanged.
  - err_count is still updated if err=1.
- Output handshake:
  - dout_valid stays high and dout/parity_err stay stable until dout_valid & dout_ready.
  - On that cycle dout_valid clears, unless a completion loads a new word in the same cycle.
- err_count: increments on every completed frame with err=1, whether delivered or dropped. It saturates at 2^ERR_CNT_W-1 with no wrap. It is cleared only by rst.
- Reception is independent of output backpressure; a new frame may be received while dout is held.
- Reset mid-frame: all state returns to reset values immediately. The partial frame is lost with no pulses.

Test Plan:
- DATA_W=8, even parity. Send start plus 0xA5 LSB-first, then parity bit 0, with dout_ready=1 → dout_valid 1 cycle after the parity bit, dout=0xA5, parity_err=0, err_count=0.
- Send 0xA5 with parity bit 1, then 0x01 with parity bit 1 → first word parity_err=1, second parity_err=0, err_count=1. With ODD_PARITY=1, 0xA5 plus parity bit 1 → parity_err=0.
- Hold dout_ready=0. Send 0x3C (parity 0), then 0x81 (parity 1) → dout stays 0x3C, overrun pulses once, and 0x81 is never seen. Raise dout_ready for one cycle → handshake completes. Next frame 0x7E is delivered.
- Send start plus 5 bits of 0xFF, then start plus 0x12 with parity 0 → frame_abort pulses once, the only output is dout=0x12, parity_err=0.
- ERR_CNT_W=2. Send 5 frames with bad parity → err_count goes 1, 2, 3, 3, 3.
- Assert rst after 4 data bits, release, send 0x55 with parity 0 → no output during reset, all outputs 0. Afterwards dout=0x55, parity_err=0. Also cover a gapped sin_valid stream: gaps do not change results.

Source files
------------

// File: rtl/xor_parity_rx.sv
// xor_parity_rx: serial frame receiver with running-XOR parity check.
// Frames arrive LSB-first: DATA_W data bits, then one parity bit. The
// deserialised word and its pass/fail flag go out on a one-entry output slot.
//
// Output handshake: dout_valid, dout and parity_err are held stable from the
// cycle dout_valid rises until the cycle dout_valid & dout_ready is true. The
// word transfers on that rising edge. A frame that completes while the slot is
// held (dout_valid & !dout_ready) is dropped and reported on overrun.
module xor_parity_rx #(
  parameter int DATA_W     = 8,
  parameter int ODD_PARITY = 0,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sin_valid,
  input  logic                 sin_bit,
  input  logic                 sin_start,
  output logic [DATA_W-1:0]    dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 parity_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 overrun,
  output logic                 frame_abort
);

  localparam int   CNT_W = $clog2(DATA_W + 1);
  localparam logic ODD   = (ODD_PARITY != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              xr, xr_nxt;
  logic              complete;
  logic              frame_err;
  logic              abort_nxt;
  logic              slot_free;

  // The slot can take a new word if empty or being emptied this same cycle.
  assign slot_free = !dout_valid || dout_ready;

  // Next-state and frame datapath; a start bit restarts from any state.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    xr_nxt    = xr;
    complete  = 1'b0;
    frame_err = 1'b0;
    abort_nxt = 1'b0;
    if (sin_valid) begin
      if (sin_start) begin
        abort_nxt = (state != IDLE);
        shreg_nxt = DATA_W'(sin_bit);
        xr_nxt    = sin_bit;
        cnt_nxt   = CNT_W'(1);
        state_nxt = DATA;
      end else begin
        case (state)
          DATA: begin
            // Bits above cnt are still zero since the start cleared them.
            shreg_nxt = shreg | (DATA_W'(sin_bit) << cnt);
            xr_nxt    = xr ^ sin_bit;
            cnt_nxt   = cnt + CNT_W'(1);
            if (cnt == CNT_W'(DATA_W - 1)) state_nxt = PARITY;
          end
          PARITY: begin
            complete  = 1'b1;
            frame_err = xr ^ sin_bit ^ ODD;
            cnt_nxt   = '0;
            xr_nxt    = 1'b0;
            state_nxt = IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  // Frame state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      xr    <= 1'b0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      cnt   <= cnt_nxt;
      xr    <= xr_nxt;
    end
  end

  // Output slot, status pulses and saturating parity error counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout        <= '0;
      dout_valid  <= 1'b0;
      parity_err  <= 1'b0;
      err_count   <= '0;
      overrun     <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      overrun     <= complete && !slot_free;
      frame_abort <= abort_nxt;
      if (complete && slot_free) begin
        dout       <= shreg;
        parity_err <= frame_err;
        dout_valid <= 1'b1;
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
      if (complete && frame_err && (err_count != '1)) begin
        err_count <= err_count + ERR_CNT_W'(1);
      end
    end
  end

endmodule
